ysyx_23060332_lsu: RTL

- Load/store unit directly downstream of the execute stage; consumes the effective address, store data and load/store decode produced there.
- Performs the memory access over a request/response bus, aligns store data and byte strobes, extracts and extends load data, and forwards the register write-back to the write-back stage.
- Non-memory instructions pass through with their ALU result.
- Replaces the combinational zero-latency memory path with a multi-cycle handshaked access.

---
 rtl/ysyx_23060332_lsu.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: turns an executed instruction into one handshaked bus access
// (aligned store lanes, extracted/extended load data) and hands the result to write-back.
module ysyx_23060332_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [2:0]        in_func3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_wen,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_reg_wen,
    output logic              out_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, OUT} state_t;

    state_t      state_q;
    logic        is_load_q;
    logic        reg_wen_q;
    logic [2:0]  func3_q;
    logic [1:0]  off_q;

    logic [1:0]        in_off;
    logic              in_is_mem;
    logic              misalign_d;
    logic [3:0]        st_wstrb_d;
    logic [DATA_W-1:0] st_wdata_d;
    logic [DATA_W-1:0] ld_lane;
    logic [DATA_W-1:0] ld_data_d;

    assign in_off    = in_addr[1:0];
    assign in_is_mem = in_is_load | in_is_store;

    always_comb begin
        misalign_d = 1'b0;
        case (in_func3)
            3'b001, 3'b101: misalign_d = in_off[0];
            3'b010:         misalign_d = (in_off != 2'b00);
            default:        misalign_d = 1'b0;
        endcase
    end

    // Narrow stores replicate the datum across every lane; strobes pick the live bytes.
    always_comb begin
        st_wstrb_d = 4'b0000;
        st_wdata_d = in_wdata;
        case (in_func3)
            3'b000: begin
                st_wstrb_d = 4'b0001 << in_off;
                st_wdata_d = {4{in_wdata[7:0]}};
            end
            3'b001: begin
                st_wstrb_d = 4'b0011 << in_off;
                st_wdata_d = {2{in_wdata[15:0]}};
            end
            3'b010: st_wstrb_d = 4'b1111;
            default: st_wstrb_d = 4'b0000;
        endcase
    end

    assign ld_lane = mem_rsp_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_data_d = '0;
        case (func3_q)
            3'b000:  ld_data_d = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'b001:  ld_data_d = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'b010:  ld_data_d = ld_lane;
            3'b100:  ld_data_d = {24'd0, ld_lane[7:0]};
            3'b101:  ld_data_d = {16'd0, ld_lane[15:0]};
            default: ld_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= 4'b0000;
            out_valid     <= 1'b0;
            out_rd        <= 5'd0;
            out_wdata     <= '0;
            out_reg_wen   <= 1'b0;
            out_misalign  <= 1'b0;
            is_load_q     <= 1'b0;
            reg_wen_q     <= 1'b0;
            func3_q       <= 3'b000;
            off_q         <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready      <= 1'b0;
                        out_rd        <= in_rd;
                        is_load_q     <= in_is_load;
                        reg_wen_q     <= in_reg_wen;
                        func3_q       <= in_func3;
                        off_q         <= in_off;
                        mem_req_wen   <= in_is_store;
                        mem_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                        mem_req_wdata <= st_wdata_d;
                        mem_req_wstrb <= in_is_store ? st_wstrb_d : 4'b0000;
                        if (!in_is_mem) begin
                            out_valid    <= 1'b1;
                            out_wdata    <= in_alu_result;
                            out_reg_wen  <= in_reg_wen;
                            out_misalign <= 1'b0;
                            state_q      <= OUT;
                        end else if (misalign_d) begin
                            out_valid    <= 1'b1;
                            out_wdata    <= '0;
                            out_reg_wen  <= 1'b0;
                            out_misalign <= 1'b1;
                            state_q      <= OUT;
                        end else begin
                            mem_req_valid <= 1'b1;
                            state_q       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_q       <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // Stores complete on their response too, but never write a register.
                    if (mem_rsp_valid) begin
                        out_valid    <= 1'b1;
                        out_wdata    <= is_load_q ? ld_data_d : '0;
                        out_reg_wen  <= is_load_q & reg_wen_q;
                        out_misalign <= 1'b0;
                        state_q      <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
